// File: rtl/noc_trace_recorder_if.sv
// Trace recorder bus bundle: the monitored NoC injection handshake plus the
// outgoing trace-entry stream. The recorder takes the slave view; whatever
// drives the injection port and sinks the trace stream takes the master view.
interface noc_trace_recorder_if #(
    parameter int A_W   = 8,
    parameter int VC_W  = 4,
    parameter int IDX_W = 10
);
    logic             mon_valid;
    logic             mon_ready;
    logic [VC_W-1:0]  mon_vc;
    logic [A_W-1:0]   mon_dest;
    logic             mon_stall;
    logic             tr_valid;
    logic             tr_ready;
    logic [15:0]      tr_data;
    logic [IDX_W-1:0] tr_index;

    modport slave (
        input  mon_valid, mon_ready, mon_vc, mon_dest, tr_ready,
        output mon_stall, tr_valid, tr_data, tr_index
    );

    modport master (
        output mon_valid, mon_ready, mon_vc, mon_dest, tr_ready,
        input  mon_stall, tr_valid, tr_data, tr_index
    );
endinterface

// File: rtl/noc_trace_recorder.sv
// noc_trace_recorder: passively watches a PE's NoC injection handshake, packs
// each accepted packet into a 16-bit trace entry
// {unused[2:0], stop_bit, vc[3:0], dest[7:0]}, buffers entries in a small FIFO
// and streams them to a trace-memory writer. The last entry of a recording
// carries stop_bit=1 so the stream replays directly as trace traffic.
// Optional build macro NOC_TRACE_RECORDER_STALL_EN: registered mon_stall
// asserted in RECORD while the FIFO is within one slot of full.
module noc_trace_recorder #(
    parameter int A_W         = 8,
    parameter int VC_W        = 4,
    parameter int FIFO_DEPTH  = 16,
    parameter int MAX_ENTRIES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    noc_trace_recorder_if.slave  bus,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic [15:0]          drop_count
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = $clog2(MAX_ENTRIES);
    localparam int ENT_W = $clog2(MAX_ENTRIES) + 1;
    localparam logic [ENT_W-1:0] ENT_LIMIT = ENT_W'(MAX_ENTRIES - 1);
    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [15:0]      SENTINEL  = 16'hF000;

    typedef enum logic [1:0] {IDLE, RECORD, FLUSH, DONE} state_t;

    state_t             state_reg, state_next;
    logic [15:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]   fifo_count_reg, fifo_count_next;
    logic [ENT_W-1:0]   entry_count_reg;
    logic [IDX_W-1:0]   index_reg;
    logic               overflow_reg;
    logic [15:0]        drop_count_reg;

    logic               capture, fifo_empty, fifo_full, sentinel;
    logic               handshake, pop, push, drop, limit_hit, start_rec;
    logic [15:0]        entry;
    logic [15:0]        head;

    // Capture / FIFO status decode
    assign capture    = bus.mon_valid & bus.mon_ready;
    assign fifo_empty = (fifo_count_reg == '0);
    assign fifo_full  = (fifo_count_reg == FIFO_FULL);
    // In FLUSH nothing is pushed and the FSM leaves as soon as the stop entry is
    // taken, so an empty FIFO in FLUSH can only mean FLUSH was entered empty.
    assign sentinel   = (state_reg == FLUSH) && fifo_empty;
    assign handshake  = bus.tr_valid & bus.tr_ready;
    assign pop        = handshake & ~fifo_empty;
    assign limit_hit  = (entry_count_reg >= ENT_LIMIT);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push       = (state_reg == RECORD) && capture && (!fifo_full || pop) && !limit_hit;
    // Captures after the entry limit forced FLUSH are still accounted as drops.
    assign drop       = capture && (((state_reg == RECORD) && !push) ||
                                    ((state_reg == FLUSH) && limit_hit));
    assign start_rec  = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign entry      = {3'b000, 1'b0, 4'(bus.mon_vc), 8'(bus.mon_dest)};
    assign head       = mem[rd_ptr_reg];

    assign bus.tr_valid = !fifo_empty || sentinel;
    assign bus.tr_index = index_reg;
    assign busy         = (state_reg == RECORD) || (state_reg == FLUSH);
    assign done         = (state_reg == DONE);
    assign overflow     = overflow_reg;
    assign drop_count   = drop_count_reg;

    // Output entry: FIFO head with the stop bit forced on the final buffered entry
    always_comb begin
        bus.tr_data = '0;
        if (!fifo_empty) begin
            bus.tr_data = head;
            if ((state_reg == FLUSH) && (fifo_count_reg == CNT_W'(1))) begin
                bus.tr_data[12] = 1'b1;
            end
        end else if (sentinel) begin
            bus.tr_data = SENTINEL;
        end
    end

    // Next-state logic for the recording FSM
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:   if (start) state_next = RECORD;
            RECORD: if (stop || (push && ((entry_count_reg + ENT_W'(1)) == ENT_LIMIT)))
                        state_next = FLUSH;
            FLUSH:  if (handshake && (fifo_count_reg <= CNT_W'(1))) state_next = DONE;
            DONE:   if (start) state_next = RECORD;
            default: state_next = IDLE;
        endcase
    end

    // Next FIFO occupancy; a new recording always starts from an empty FIFO
    always_comb begin
        fifo_count_next = fifo_count_reg;
        if (start_rec) begin
            fifo_count_next = '0;
        end else begin
            case ({push, pop})
                2'b10:   fifo_count_next = fifo_count_reg + CNT_W'(1);
                2'b01:   fifo_count_next = fifo_count_reg - CNT_W'(1);
                default: fifo_count_next = fifo_count_reg;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
        end else begin
            fifo_count_reg <= fifo_count_next;
            if (start_rec) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
        end
    end

    // Entry storage; contents are don't-care whenever the count says empty
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= entry;
    end

    // Pushed-entry count and output sequence number, both per recording
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_count_reg <= '0;
            index_reg       <= '0;
        end else if (start_rec) begin
            entry_count_reg <= '0;
            index_reg       <= '0;
        end else begin
            if (push)      entry_count_reg <= entry_count_reg + ENT_W'(1);
            if (handshake) index_reg       <= index_reg + IDX_W'(1);
        end
    end

    // Sticky overflow flag and saturating drop counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_reg   <= 1'b0;
            drop_count_reg <= '0;
        end else if (start_rec) begin
            overflow_reg   <= 1'b0;
            drop_count_reg <= '0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
            if (drop_count_reg != 16'hFFFF) drop_count_reg <= drop_count_reg + 16'd1;
        end
    end

`ifdef NOC_TRACE_RECORDER_STALL_EN
    logic stall_reg;

    // Registered stall: computed from next-cycle state/occupancy so it lines up
    // with the cycle in which the FIFO is within one slot of full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_reg <= 1'b0;
        else     stall_reg <= (state_next == RECORD) &&
                              (fifo_count_next >= CNT_W'(FIFO_DEPTH - 1));
    end

    assign bus.mon_stall = stall_reg;
`else
    assign bus.mon_stall = 1'b0;
`endif

endmodule
